bip_core_param: RTL
===================

# bip_core_param

Parametrised BIP accumulator processor core: program memory, data memory, accumulator datapath and run-control FSM in one block, sized by parameters instead of a fixed 16-bit/2K build. Adds what the fixed core lacks: a program-load port, start/halt run control, a debug read port into data memory, and a cycle counter. Sits under the BIP top level as its only compute element; the top level supplies clock, reset and the load/debug buses.

## Interface
- DATA_W, 16, data/instruction word width; accumulator and memories are DATA_W wide
- OPC_W, 5, opcode field width (instruction bits [DATA_W-1 -: OPC_W])
- PC_W, 11, program counter / program address width; program memory depth 2**PC_W
- DADDR_W, 10, data memory address width; depth 2**DADDR_W
- OPND_W (derived, DATA_W-OPC_W, 11): operand field width; must be ≥ PC_W and ≥ DADDR_W

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all registers, not the memories
- prog_we  in  1  program memory write strobe, honoured only when busy=0
- prog_addr  in  PC_W  program write address
- prog_data  in  DATA_W  program write word
- start  in  1  one-cycle pulse; begins execution at PC 0
- dbg_addr  in  DADDR_W  data memory debug read address
- dbg_data  out  DATA_W  combinational read of data memory at dbg_addr
- acc  out  DATA_W  accumulator
- pc  out  PC_W  program counter
- busy  out  1  high in FETCH and EXEC
- halted  out  1  high in HALT
- cycle_count  out  32  busy cycles since last start

## Operation
- Reset values: acc=0, pc=0, busy=0, halted=0, cycle_count=0, state IDLE. Memories keep contents.
- FSM: IDLE -(start)-> FETCH -> EXEC -> FETCH … ; EXEC with HLT -> HALT; HALT -(start)-> FETCH.
- start in IDLE or HALT: pc←0, acc←0, cycle_count←0, halted←0. start while busy: ignored.
- FETCH: program memory synchronous read of pc into instruction register.
- EXEC: decode and commit; pc←pc+1 (mod 2**PC_W) except on HLT and taken branch.
- Operand: imm = sign-extended operand field to DATA_W; daddr = operand[DADDR_W-1:0].
- Opcodes: 00000 HLT; 00001 STO mem[daddr]←acc; 00010 LD acc←mem[daddr]; 00011 LDI acc←imm; 00100 ADD acc←acc+mem; 00101 ADDI acc←acc+imm; 00110 SUB acc←acc−mem; 00111 SUBI acc←acc−imm.
- Arithmetic two's-complement, wraps mod 2**DATA_W, no flags.
- Any other opcode: NOP (pc advances).
- prog_we with busy=1: dropped. Program writes in IDLE/HALT take effect next cycle.
- cycle_count increments every FETCH/EXEC cycle, saturates at 2**32−1.
- dbg_data reflects a same-cycle STO only after the commit edge.

## Timing
- start sampled at edge k → FETCH during k+1 (busy=1), EXEC during k+2.
- Two cycles per instruction; acc/mem/pc update on the edge ending EXEC.
- HLT in EXEC at cycle n → halted=1, busy=0 from n+1; pc holds HLT address.
- N instructions including HLT: cycle_count = 2N at halt.
- reset asserted mid-instruction: outputs return to reset values immediately; no partial STO commit.

## Configuration
- BIP_BRANCH_EN defined: adds 01000 BEQ (if acc==0 pc←operand[PC_W-1:0]) and 01001 JMP (pc←operand[PC_W-1:0]); taken branch costs no extra cycle.
- Undefined: 01000/01001 are NOPs; branch logic absent.

## Test plan
- Load LDI 5, ADDI 3, STO 0, HLT; start → acc=8, mem[0]=8 via dbg, pc=3, halted=1, cycle_count=8.
- LDI −1 (operand 0x7FF), ADDI 1 → acc=0x0000 (wrap); SUBI 1 → acc=0xFFFF.
- prog_we and second start pulsed while busy → program and pc unaffected; rerun after halt restarts at pc 0 with acc=0, cycle_count reset.
- reset asserted during EXEC of STO 5 → mem[5] unchanged, acc=0, pc=0, busy=0; program memory intact, start reruns correctly.
- BIP_BRANCH_EN: LDI 3; SUBI 1; BEQ 4; JMP 1; HLT → halts with acc=0, pc=4, cycle_count=20; without macro → runs straight to HLT, acc=2, cycle_count=10.
- Undefined opcode 11111 between LDI 7 and HLT → acc=7, treated as NOP, pc advances.

Source files
------------

// File: rtl/bip_core_param_if.sv
// bip_core_param_if: load/run/debug bus of the BIP core.
// Signals: prog_we/prog_addr/prog_data program write port, start run pulse,
// dbg_addr/dbg_data data memory debug read, acc/pc/busy/halted/cycle_count status.
// Modports: slave (core side), master (driver side).
interface bip_core_param_if #(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 11,
   parameter int DADDR_W = 10
);
   logic               prog_we;
   logic [PC_W-1:0]    prog_addr;
   logic [DATA_W-1:0]  prog_data;
   logic               start;
   logic [DADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0]  dbg_data;
   logic [DATA_W-1:0]  acc;
   logic [PC_W-1:0]    pc;
   logic               busy;
   logic               halted;
   logic [31:0]        cycle_count;
   modport slave (
      input  prog_we, prog_addr, prog_data, start, dbg_addr,
      output dbg_data, acc, pc, busy, halted, cycle_count
   );
   modport master (
      output prog_we, prog_addr, prog_data, start, dbg_addr,
      input  dbg_data, acc, pc, busy, halted, cycle_count
   );
endinterface

// File: rtl/bip_core_param.sv
// bip_core_param: parametrised BIP accumulator core with program load, run control and debug read.
// Ports: clk, reset (async, active-high), bus (bip_core_param_if.slave).
// Optional BEQ/JMP branch opcodes enabled by defining BIP_BRANCH_EN.
module bip_core_param #(
   parameter int DATA_W  = 16,
   parameter int OPC_W   = 5,
   parameter int PC_W    = 11,
   parameter int DADDR_W = 10
) (
   input logic             clk,
   input logic             reset,
   bip_core_param_if.slave bus
);
   localparam int OPND_W = DATA_W - OPC_W;
   localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
`ifdef BIP_BRANCH_EN
   localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(9);
`endif
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]   ir_q;
   logic [DATA_W-1:0]   pmem_q [2**PC_W];
   logic [DATA_W-1:0]   dmem_q [2**DADDR_W];
   logic [OPC_W-1:0]    opc;
   logic [OPND_W-1:0]   opnd;
   logic [DATA_W-1:0]   imm;
   logic [DADDR_W-1:0]  daddr;
   logic [DATA_W-1:0]   mem_rd;
   logic                busy;
   logic                dmem_we;
   assign opc     = ir_q[DATA_W-1 -: OPC_W];
   assign opnd    = ir_q[OPND_W-1:0];
   assign imm     = {{OPC_W{opnd[OPND_W-1]}}, opnd};
   assign daddr   = opnd[DADDR_W-1:0];
   assign mem_rd  = dmem_q[daddr];
   assign busy    = (state_q == FETCH) || (state_q == EXEC);
   // state_q is forced to IDLE by reset, so an interrupted STO never commits
   assign dmem_we = (state_q == EXEC) && (opc == OP_STO);
   assign bus.dbg_data    = dmem_q[bus.dbg_addr];
   assign bus.acc         = acc_q;
   assign bus.pc          = pc_q;
   assign bus.busy        = busy;
   assign bus.halted      = state_q == HALT;
   assign bus.cycle_count = cnt_q;
   // memories are not reset; contents survive reset
   always_ff @(posedge clk) begin
      if (bus.prog_we && !busy) pmem_q[bus.prog_addr] <= bus.prog_data;
      if (dmem_we) dmem_q[daddr] <= acc_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         if (state_q == FETCH) ir_q <= pmem_q[pc_q];
      end
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      cnt_d   = busy ? ((&cnt_q) ? cnt_q : cnt_q + 32'd1) : cnt_q;
      case (state_q)
         IDLE, HALT: begin
            if (bus.start) begin
               state_d = FETCH;
               pc_d    = '0;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         FETCH: state_d = EXEC;
         default: begin
            state_d = FETCH;
            pc_d    = pc_q + 1'b1;
            case (opc)
               OP_HLT: begin
                  state_d = HALT;
                  pc_d    = pc_q;
               end
               OP_LD:   acc_d = mem_rd;
               OP_LDI:  acc_d = imm;
               OP_ADD:  acc_d = acc_q + mem_rd;
               OP_ADDI: acc_d = acc_q + imm;
               OP_SUB:  acc_d = acc_q - mem_rd;
               OP_SUBI: acc_d = acc_q - imm;
`ifdef BIP_BRANCH_EN
               OP_BEQ:  pc_d = (acc_q == '0) ? opnd[PC_W-1:0] : pc_d;
               OP_JMP:  pc_d = opnd[PC_W-1:0];
`endif
               default: ;
            endcase
         end
      endcase
   end
endmodule
